// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, counter width and pixel types for the scanout path.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam int CNT_W = 10;

  typedef logic [11:0] rgb12_t;

  // Flags carried down the alignment pipeline; sync bits are active-high here
  // so a cleared pipeline means "not in sync".
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic origin;
  } sync_flags_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical scan counters and the raw timing flags decoded from them.
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       active,
  output logic       vblank,
  output logic       origin
);
  import vga_timing_pkg::*;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign hsync_raw = !((h_cnt >= HS_LO) && (h_cnt < HS_HI));
  assign vsync_raw = !((v_cnt >= VS_LO) && (v_cnt < VS_HI));
  assign active    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign vblank    = (v_cnt >= V_VIS);
  assign origin    = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer read side: address generation, 3-stage sync/data alignment and
// frame_start on top of the scan counters.
module vga_scanout #(
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP        = vga_timing_pkg::H_FP,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP        = vga_timing_pkg::V_FP,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP,
  parameter int SCALE_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [11:0] rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] vga_rgb,
  output logic        blank,
  output logic        vblank,
  output logic        frame_start
);
  import vga_timing_pkg::*;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             hsync_raw;
  logic             vsync_raw;
  logic             active;
  logic             origin;
  logic [7:0]       fb_x;
  logic [7:0]       fb_y;
  sync_flags_t      cur;
  sync_flags_t      s1;
  sync_flags_t      s2;
  logic             strobe_d;
  rgb12_t           data_hold;
  rgb12_t           pix_data;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_en    (pix_en),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .active    (active),
    .vblank    (vblank),
    .origin    (origin)
  );

  assign fb_x = 8'(h_cnt >> SCALE_SHIFT);
  assign fb_y = 8'(v_cnt >> SCALE_SHIFT);

  always_comb begin
    cur        = '0;
    cur.hsync  = !hsync_raw;
    cur.vsync  = !vsync_raw;
    cur.active = active;
    cur.origin = origin;
  end

  // S1 issues the read; S2 waits out the memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      s1      <= '0;
      s2      <= '0;
    end else if (pix_en) begin
      rd_en <= cur.active;
      if (cur.active) begin
        rd_addr <= {fb_y, fb_x};
      end
      s1 <= cur;
      s2 <= s1;
    end
  end

  // The memory keeps reading every clk, so once rd_addr has moved on to the
  // next pixel rd_data no longer belongs to S2. Capture it on the clk right
  // after each strobe, and bypass the capture when S3 fires on that same clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_d  <= 1'b0;
      data_hold <= '0;
    end else begin
      strobe_d <= pix_en;
      if (strobe_d) begin
        data_hold <= rd_data;
      end
    end
  end

  assign pix_data = strobe_d ? rd_data : data_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_rgb <= '0;
      blank   <= 1'b1;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else if (pix_en) begin
      vga_rgb <= s2.active ? pix_data : '0;
      blank   <= !s2.active;
      hsync   <= !s2.hsync;
      vsync   <= !s2.vsync;
    end
  end

  // Re-evaluated every clk so the pulse lasts one clk even at low strobe rates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && s2.origin;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout on a reduced screen geometry, checked
// against a strobe-count model of the scan position.
module tb_vga_scanout;

  localparam int HA = 40, HF = 4, HS = 8, HB = 6;
  localparam int VA = 24, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [11:0] rd_data = '0;
  logic        hsync;
  logic        vsync;
  logic [11:0] vga_rgb;
  logic        blank;
  logic        vblank;
  logic        frame_start;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;
  int fs_seen = 0;
  int hs_low = 0;
  int vs_low = 0;
  int vb_high = 0;
  bit measuring = 1'b0;

  typedef struct {
    int          h;
    int          v;
    logic [15:0] addr;
    logic        en;
  } addr_vec_t;

  addr_vec_t addr_tab[7];

  vga_scanout #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SCALE_SHIFT (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .hsync       (hsync),
    .vsync       (vsync),
    .vga_rgb     (vga_rgb),
    .blank       (blank),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] fb_colour(input int x, input int y);
    logic [7:0] xb;
    logic [7:0] yb;
    xb = 8'(x);
    yb = 8'(y);
    return {xb[3:0], yb[3:0], 4'hA};
  endfunction

  // Synchronous framebuffer port: one clk latency, reads every clk.
  always @(posedge clk) rd_data <= fb_colour(int'(rd_addr[7:0]), int'(rd_addr[15:8]));

  task automatic checkOutput(input bit strobed);
    logic        e_hs, e_vs, e_bl, e_fs, e_vb, e_en;
    logic [11:0] e_rgb;
    logic [15:0] e_addr;
    int          p, h, v;
    bit          bad;
    e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b1; e_fs = 1'b0; e_en = 1'b0;
    e_rgb = '0; e_addr = '0;
    if (n >= 3) begin
      p = (n - 3) % FRAME;
      h = p % HT;
      v = p / HT;
      e_bl  = !(h < HA && v < VA);
      e_rgb = e_bl ? 12'h000 : fb_colour(h / 4, v / 4);
      e_hs  = !(h >= HA + HF && h < HA + HF + HS);
      e_vs  = !(v >= VA + VF && v < VA + VF + VS);
      e_fs  = strobed && (p == 0);
    end
    if (n >= 1) begin
      p = (n - 1) % FRAME;
      h = p % HT;
      v = p / HT;
      e_en   = (h < HA && v < VA);
      e_addr = {8'(v / 4), 8'(h / 4)};
    end
    e_vb = ((n % FRAME) / HT) >= VA;
    vectors++;
    bad = (hsync !== e_hs) || (vsync !== e_vs) || (blank !== e_bl) || (vga_rgb !== e_rgb) ||
          (frame_start !== e_fs) || (vblank !== e_vb) || (rd_en !== e_en) ||
          (e_en && rd_addr !== e_addr);
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL pixel n=%0d: got hs=%b vs=%b bl=%b rgb=%h fs=%b vb=%b en=%b addr=%h, want hs=%b vs=%b bl=%b rgb=%h fs=%b vb=%b en=%b addr=%h",
               n, hsync, vsync, blank, vga_rgb, frame_start, vblank, rd_en, rd_addr,
               e_hs, e_vs, e_bl, e_rgb, e_fs, e_vb, e_en, e_addr);
    end
    if (measuring) begin
      if (frame_start) fs_seen++;
      if (strobed && !hsync) hs_low++;
      if (strobed && !vsync) vs_low++;
      if (strobed && vblank) vb_high++;
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit pe);
    pix_en = pe;
    @(posedge clk);
    #1;
    if (pe) n++;
    checkOutput(pe);
  endtask

  task automatic doReset();
    rst_n  = 1'b0;
    pix_en = 1'b1;
    n      = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput(1'b1);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    addr_tab[0] = '{h: 5,  v: 9,  addr: 16'h0201, en: 1'b1};
    addr_tab[1] = '{h: 0,  v: 0,  addr: 16'h0000, en: 1'b1};
    addr_tab[2] = '{h: 12, v: 4,  addr: 16'h0103, en: 1'b1};
    addr_tab[3] = '{h: 39, v: 23, addr: 16'h0509, en: 1'b1};
    addr_tab[4] = '{h: 40, v: 0,  addr: 16'h0009, en: 1'b0};
    addr_tab[5] = '{h: 7,  v: 24, addr: 16'h0509, en: 1'b0};
    addr_tab[6] = '{h: 57, v: 30, addr: 16'h0509, en: 1'b0};

    $display("[TB] reset hold");
    #2;
    doReset();

    $display("[TB] address mapping table");
    for (int i = 0; i < 7; i++) begin
      doReset();
      repeat (addr_tab[i].v * HT + addr_tab[i].h + 1) applyStimulus(1'b1);
      checkValue($sformatf("rd_en(%0d,%0d)", addr_tab[i].h, addr_tab[i].v),
                 int'(rd_en), int'(addr_tab[i].en));
      checkValue($sformatf("rd_addr(%0d,%0d)", addr_tab[i].h, addr_tab[i].v),
                 int'(rd_addr), int'(addr_tab[i].addr));
    end

    $display("[TB] asynchronous reset mid-line");
    doReset();
    repeat (3 + HT + 20) applyStimulus(1'b1);
    checkValue("pre-reset blank", int'(blank), 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("async hsync", int'(hsync), 1);
    checkValue("async vsync", int'(vsync), 1);
    checkValue("async blank", int'(blank), 1);
    checkValue("async vga_rgb", int'(vga_rgb), 0);
    checkValue("async rd_en", int'(rd_en), 0);
    checkValue("async rd_addr", int'(rd_addr), 0);
    checkValue("async frame_start", int'(frame_start), 0);
    checkValue("async vblank", int'(vblank), 0);

    $display("[TB] full-rate scan");
    doReset();
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      measuring = (n >= 999 && n < 999 + FRAME);
      applyStimulus(1'b1);
    end
    measuring = 1'b0;
    checkValue("frame_start per frame", fs_seen, 1);
    checkValue("hsync low strobes per frame", hs_low, VT * HS);
    checkValue("vsync low strobes per frame", vs_low, VS * HT);
    checkValue("vblank strobes per frame", vb_high, (VT - VA) * HT);

    $display("[TB] half-rate scan");
    doReset();
    for (int i = 0; i < 2 * (FRAME + 20); i++) applyStimulus(i % 2 == 0);

    $display("[TB] random strobe scan");
    doReset();
    fs_seen = 0;
    measuring = 1'b1;
    for (int i = 0; i < FRAME + 300; i++) applyStimulus(1'($urandom_range(0, 1)));
    measuring = 1'b0;
    checkValue("random frame_start pulses", fs_seen, (n >= 3 + FRAME) ? 2 : 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
